// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle datapath.
// It decodes INSTRUCTION_OUT and FLAGS and drives every datapath strobe and mux select.
module multicycle_control_unit #(
    parameter bit         ENABLE_BL  = 1'b1,
    parameter logic [2:0] IDLE_SHIFT = 3'b111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_out,
    output logic        instr_done
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0, DECODE  = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB  = 4'd4,
        MEMWRITE = 4'd5, EXECR   = 4'd6, EXECI  = 4'd7, ALUWB   = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t state, state_nxt;

    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic       i_bit, s_bit, link;
    logic       n_f, z_f, c_f, v_f;
    logic       cond_pass, cmd_ok, is_cmp;
    logic [2:0] alu_dp;
    logic       unused_instr_bits;

    assign cond   = INSTRUCTION_OUT[31:28];
    assign op     = INSTRUCTION_OUT[27:26];
    assign i_bit  = INSTRUCTION_OUT[25];
    assign cmd    = INSTRUCTION_OUT[24:21];
    assign s_bit  = INSTRUCTION_OUT[20];
    assign link   = INSTRUCTION_OUT[24];
    assign is_cmp = (cmd == 4'b1010);
    assign {n_f, z_f, c_f, v_f} = FLAGS;
    assign unused_instr_bits = ^{INSTRUCTION_OUT[19:7], INSTRUCTION_OUT[4:0]};
    assign state_out = state;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        cmd_ok = 1'b1;
        alu_dp = 3'b000;
        case (cmd)
            4'b0100: alu_dp = 3'b000;
            4'b0010: alu_dp = 3'b001;
            4'b1010: alu_dp = 3'b001;
            4'b0000: alu_dp = 3'b010;
            4'b1100: alu_dp = 3'b011;
            4'b1101: alu_dp = 3'b100;
            default: cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = FETCH;
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        RegSrc     = 2'b00;
        ALUop      = 3'b000;
        ShiftType  = IDLE_SHIFT;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1; PCWrite = 1'b1;
                ALUSrcB = 2'b11; ResultSrc = 2'b10; RegSrc = 2'b10;
                state_nxt = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11; ResultSrc = 2'b10; RegSrc = 2'b10;
                // Condition failure and unsupported encodings both retire here.
                if (!cond_pass)                   instr_done = 1'b1;
                else if (op == 2'b01 && !i_bit)   state_nxt = MEMADR;
                else if (op == 2'b00 && cmd_ok)   state_nxt = i_bit ? EXECI : EXECR;
                else if (op == 2'b10)             state_nxt = BRANCH;
                else                              instr_done = 1'b1;
            end
            MEMADR: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01; RegSrc = 2'b10;
                state_nxt = s_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b01; RegSrc = 2'b10;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                AdrSrc = 1'b1; RegWrite = 1'b1; ResultSrc = 2'b01; RegSrc = 2'b10;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1; MemWrite = 1'b1; RegSrc = 2'b10;
                instr_done = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b01; ALUop = alu_dp;
                ShiftType = {1'b0, INSTRUCTION_OUT[6:5]};
                state_nxt = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01; ALUop = alu_dp;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                ALUop = alu_dp;
                RegWrite = !is_cmp;
                FlagUpdate = s_bit || is_cmp;
                instr_done = 1'b1;
            end
            BRANCH: begin
                PCWrite = 1'b1; ALUSrcB = 2'b01; ResultSrc = 2'b10; RegSrc = 2'b01;
                instr_done = 1'b1;
                if (link && ENABLE_BL) begin
                    RegWrite = 1'b1; A3Src = 1'b1; WD3Src = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase
        // Reset overrides everything so that a write in progress cannot complete.
        if (reset) begin
            A3Src = 1'b0; AdrSrc = 1'b0; FlagUpdate = 1'b0; IRWrite = 1'b0;
            MemWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0; WD3Src = 1'b0;
            ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; RegSrc = 2'b00;
            ALUop = 3'b000; ShiftType = IDLE_SHIFT; instr_done = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit.
// Each row's expected output word is queued when the row is driven, then popped and compared.
module tb_multicycle_control_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]  ALUop, ShiftType;
    logic [3:0]  state_out;
    logic        instr_done;

    // stb order: {A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src}
    typedef struct packed {
        logic [7:0] stb;
        logic [1:0] srca, srcb, res, regsrc;
        logic [2:0] aluop, shift;
        logic [3:0] st;
        logic       done;
    } ctl_t;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [3:0]  flags;
        logic        rst;
        logic        st_chk;
        ctl_t        exp;
    } vec_t;

    vec_t vecs[$];
    ctl_t sb[$];
    ctl_t act;
    int   n_chk = 0;
    int   n_fail = 0;

    multicycle_control_unit #(.ENABLE_BL(1'b1), .IDLE_SHIFT(3'b111)) dut (
        .clock(clock), .reset(reset), .INSTRUCTION_OUT(instr), .FLAGS(flags),
        .A3Src(A3Src), .AdrSrc(AdrSrc), .FlagUpdate(FlagUpdate), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .WD3Src(WD3Src),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegSrc(RegSrc),
        .ALUop(ALUop), .ShiftType(ShiftType), .state_out(state_out), .instr_done(instr_done)
    );

    always #5 clock = ~clock;

    assign act = {A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
                  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, state_out, instr_done};

    function automatic ctl_t mk(input logic [3:0] st, input logic [7:0] stb,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] r, input logic [1:0] g,
                                input logic [2:0] op, input logic [2:0] sh, input logic d);
        ctl_t c;
        c.stb = stb; c.srca = a; c.srcb = b; c.res = r; c.regsrc = g;
        c.aluop = op; c.shift = sh; c.st = st; c.done = d;
        return c;
    endfunction

    function automatic ctl_t fetch_c();            return mk(4'd0, 8'h14, 2'd0, 2'd3, 2'd2, 2'd2, 3'd0, 3'd7, 1'b0); endfunction
    function automatic ctl_t decode_c(input logic d); return mk(4'd1, 8'h00, 2'd0, 2'd3, 2'd2, 2'd2, 3'd0, 3'd7, d); endfunction
    function automatic ctl_t idle_c();             return mk(4'd0, 8'h00, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd7, 1'b0); endfunction
    function automatic ctl_t memadr_c();           return mk(4'd2, 8'h00, 2'd1, 2'd1, 2'd0, 2'd2, 3'd0, 3'd7, 1'b0); endfunction
    function automatic ctl_t branch_c(input logic [7:0] s); return mk(4'd9, s, 2'd0, 2'd1, 2'd2, 2'd1, 3'd0, 3'd7, 1'b1); endfunction

    task automatic push(input string tag, input logic [31:0] i, input logic [3:0] f,
                        input logic r, input logic chk, input ctl_t e);
        vec_t v;
        v.tag = tag; v.instr = i; v.flags = f; v.rst = r; v.st_chk = chk; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v);
        ctl_t e, a;
        @(negedge clock);
        instr = v.instr; flags = v.flags; reset = v.rst;
        sb.push_back(v.exp);
        #1;
        e = sb.pop_front();
        a = act;
        if (!v.st_chk) a.st = e.st;
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (state_out=%0d)", v.tag, a, e, state_out);
        end
    endtask

    task automatic run_hand(input string tag, input logic [31:0] i, input logic r, input ctl_t e, input logic chk);
        vec_t v;
        v.tag = tag; v.instr = i; v.flags = 4'b0000; v.rst = r; v.st_chk = chk; v.exp = e;
        step(v);
    endtask

    initial begin
        reset = 1'b1; instr = 32'h0; flags = 4'b0;

        push("reset0", 32'hE5900040, 4'b0000, 1'b1, 1'b0, idle_c());
        push("reset1", 32'hE5900040, 4'b0000, 1'b1, 1'b1, idle_c());
        // LDR: five cycles, register write only in MEMWB
        push("ldr_f",  32'hE5900040, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("ldr_d",  32'hE5900040, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("ldr_ma", 32'hE5900040, 4'b0000, 1'b0, 1'b1, memadr_c());
        push("ldr_mr", 32'hE5900040, 4'b0000, 1'b0, 1'b1, mk(4'd3, 8'h40, 2'd1, 2'd1, 2'd0, 2'd2, 3'd0, 3'd7, 1'b0));
        push("ldr_wb", 32'hE5900040, 4'b0000, 1'b0, 1'b1, mk(4'd4, 8'h42, 2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd7, 1'b1));
        // STR: four cycles
        push("str_f",  32'hE5810041, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("str_d",  32'hE5810041, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("str_ma", 32'hE5810041, 4'b0000, 1'b0, 1'b1, memadr_c());
        push("str_mw", 32'hE5810041, 4'b0000, 1'b0, 1'b1, mk(4'd5, 8'h48, 2'd0, 2'd0, 2'd0, 2'd2, 3'd0, 3'd7, 1'b1));
        // ADDS register form
        push("adds_f", 32'hE0902001, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("adds_d", 32'hE0902001, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("adds_x", 32'hE0902001, 4'b0000, 1'b0, 1'b1, mk(4'd6, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0));
        push("adds_w", 32'hE0902001, 4'b0000, 1'b0, 1'b1, mk(4'd8, 8'h22, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd7, 1'b1));
        // ADD with LSR shift, S=0
        push("addl_f", 32'hE0802021, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("addl_d", 32'hE0802021, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("addl_x", 32'hE0802021, 4'b0000, 1'b0, 1'b1, mk(4'd6, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1, 1'b0));
        push("addl_w", 32'hE0802021, 4'b0000, 1'b0, 1'b1, mk(4'd8, 8'h02, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd7, 1'b1));
        // CMP; FLAGS change during ALUWB must not matter
        push("cmp_f",  32'hE1500001, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("cmp_d",  32'hE1500001, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("cmp_x",  32'hE1500001, 4'b0000, 1'b0, 1'b1, mk(4'd6, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 1'b0));
        push("cmp_w",  32'hE1500001, 4'b1111, 1'b0, 1'b1, mk(4'd8, 8'h20, 2'd0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd7, 1'b1));
        // SUB, AND, MOV register forms
        push("sub_f",  32'hE0412003, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("sub_d",  32'hE0412003, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("sub_x",  32'hE0412003, 4'b0000, 1'b0, 1'b1, mk(4'd6, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 1'b0));
        push("sub_w",  32'hE0412003, 4'b0000, 1'b0, 1'b1, mk(4'd8, 8'h02, 2'd0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd7, 1'b1));
        push("and_f",  32'hE0012002, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("and_d",  32'hE0012002, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("and_x",  32'hE0012002, 4'b0000, 1'b0, 1'b1, mk(4'd6, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 3'd2, 3'd0, 1'b0));
        push("and_w",  32'hE0012002, 4'b0000, 1'b0, 1'b1, mk(4'd8, 8'h02, 2'd0, 2'd0, 2'd0, 2'd0, 3'd2, 3'd7, 1'b1));
        push("mov_f",  32'hE1A02001, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("mov_d",  32'hE1A02001, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("mov_x",  32'hE1A02001, 4'b0000, 1'b0, 1'b1, mk(4'd6, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 3'd4, 3'd0, 1'b0));
        push("mov_w",  32'hE1A02001, 4'b0000, 1'b0, 1'b1, mk(4'd8, 8'h02, 2'd0, 2'd0, 2'd0, 2'd0, 3'd4, 3'd7, 1'b1));
        // ORR immediate
        push("orr_f",  32'hE3811005, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("orr_d",  32'hE3811005, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("orr_x",  32'hE3811005, 4'b0000, 1'b0, 1'b1, mk(4'd7, 8'h00, 2'd1, 2'd1, 2'd0, 2'd0, 3'd3, 3'd7, 1'b0));
        push("orr_w",  32'hE3811005, 4'b0000, 1'b0, 1'b1, mk(4'd8, 8'h02, 2'd0, 2'd0, 2'd0, 2'd0, 3'd3, 3'd7, 1'b1));
        // BEQ not taken / taken
        push("beq0_f", 32'h0A000002, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("beq0_d", 32'h0A000002, 4'b0000, 1'b0, 1'b1, decode_c(1'b1));
        push("beq1_f", 32'h0A000002, 4'b0100, 1'b0, 1'b1, fetch_c());
        push("beq1_d", 32'h0A000002, 4'b0100, 1'b0, 1'b1, decode_c(1'b0));
        push("beq1_b", 32'h0A000002, 4'b0100, 1'b0, 1'b1, branch_c(8'h04));
        // BL writes the link register
        push("bl_f",   32'hEB000001, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("bl_d",   32'hEB000001, 4'b0000, 1'b0, 1'b1, decode_c(1'b0));
        push("bl_b",   32'hEB000001, 4'b0000, 1'b0, 1'b1, branch_c(8'h87));
        // Condition corners: GT, LT taken; HI not taken; 1111 never
        push("bgt_f",  32'hCA000000, 4'b1001, 1'b0, 1'b1, fetch_c());
        push("bgt_d",  32'hCA000000, 4'b1001, 1'b0, 1'b1, decode_c(1'b0));
        push("bgt_b",  32'hCA000000, 4'b1001, 1'b0, 1'b1, branch_c(8'h04));
        push("blt_f",  32'hBA000000, 4'b1000, 1'b0, 1'b1, fetch_c());
        push("blt_d",  32'hBA000000, 4'b1000, 1'b0, 1'b1, decode_c(1'b0));
        push("blt_b",  32'hBA000000, 4'b1000, 1'b0, 1'b1, branch_c(8'h04));
        push("bhi_f",  32'h8A000000, 4'b0110, 1'b0, 1'b1, fetch_c());
        push("bhi_d",  32'h8A000000, 4'b0110, 1'b0, 1'b1, decode_c(1'b1));
        push("bnv_f",  32'hFA000002, 4'b0100, 1'b0, 1'b1, fetch_c());
        push("bnv_d",  32'hFA000002, 4'b0100, 1'b0, 1'b1, decode_c(1'b1));
        // Unsupported encodings retire as NOPs: EOR, register-offset LDR
        push("eor_f",  32'hE0210000, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("eor_d",  32'hE0210000, 4'b0000, 1'b0, 1'b1, decode_c(1'b1));
        push("ldri_f", 32'hE7900000, 4'b0000, 1'b0, 1'b1, fetch_c());
        push("ldri_d", 32'hE7900000, 4'b0000, 1'b0, 1'b1, decode_c(1'b1));

        for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

        // Reset asserted during MEMREAD of an LDR, then the LDR is re-run to completion
        run_hand("rst_f",  32'hE5900040, 1'b0, fetch_c(), 1'b1);
        run_hand("rst_d",  32'hE5900040, 1'b0, decode_c(1'b0), 1'b1);
        run_hand("rst_ma", 32'hE5900040, 1'b0, memadr_c(), 1'b1);
        run_hand("rst_mr", 32'hE5900040, 1'b1, idle_c(), 1'b0);
        run_hand("rst_f2", 32'hE5900040, 1'b0, fetch_c(), 1'b1);
        run_hand("rst_d2", 32'hE5900040, 1'b0, decode_c(1'b0), 1'b1);
        run_hand("rst_m2", 32'hE5900040, 1'b0, memadr_c(), 1'b1);
        run_hand("rst_r2", 32'hE5900040, 1'b0, mk(4'd3, 8'h40, 2'd1, 2'd1, 2'd0, 2'd2, 3'd0, 3'd7, 1'b0), 1'b1);
        run_hand("rst_w2", 32'hE5900040, 1'b0, mk(4'd4, 8'h42, 2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd7, 1'b1), 1'b1);
        run_hand("rst_f3", 32'hE5900040, 1'b0, fetch_c(), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
